// File: rtl/delay_path_meas_ctrl_if.sv
// Host-side handshake bundle for the delay-path measurement sequencer.
// master = measurement host, slave = sequencer.
interface delay_path_meas_ctrl_if #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned ACC_W = 24
);
  logic             start;
  logic [7:0]       num_runs;
  logic             busy;
  logic             result_valid;
  logic             result_ready;
  logic [ACC_W-1:0] result_sum;
  logic [CNT_W-1:0] result_min;
  logic [CNT_W-1:0] result_max;
  logic [7:0]       runs_done;
  logic             timeout_err;

  modport master (
    output start, num_runs, result_ready,
    input  busy, result_valid, result_sum, result_min, result_max, runs_done, timeout_err
  );

  modport slave (
    input  start, num_runs, result_ready,
    output busy, result_valid, result_sum, result_min, result_max, runs_done, timeout_err
  );
endinterface

// File: rtl/delay_path_meas_ctrl.sv
// Launches edges into a delay-path chain, times their arrival in clk cycles over
// a programmed number of runs and reports sum/min/max over a valid/ready handshake.
module delay_path_meas_ctrl #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned ACC_W      = 24,
  parameter int unsigned TIMEOUT    = 1023,
  parameter int unsigned SETTLE_CYC = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  delay_path_meas_ctrl_if.slave     host,
  output logic                      pathInput,
  input  logic                      pathResult
);
  localparam int unsigned SUM_W = ACC_W + 1;
  localparam int unsigned ST_W  = $clog2(SETTLE_CYC + 1);

  if (TIMEOUT == 0 || TIMEOUT >= (1 << CNT_W)) begin : gTimeoutCheck
    $error("TIMEOUT must be in 1 .. 2**CNT_W-1");
  end

  typedef enum logic [2:0] {IDLE, SETTLE, LAUNCH, WAIT, DONE} stateT;

  stateT            state, stateNxt;
  logic             piNxt;
  logic             busy, busyNxt;
  logic             valid, validNxt;
  logic [ACC_W-1:0] sum, sumNxt;
  logic [CNT_W-1:0] minQ, minNxt, maxQ, maxNxt;
  logic [7:0]       runsDone, runsNxt, numRunsQ, numRunsNxt;
  logic             terr, terrNxt;
  logic [CNT_W-1:0] cnt, cntNxt;
  logic [ST_W-1:0]  streak, streakNxt;
  logic             sync1, resS;
  logic [SUM_W-1:0] sumWide;

  // Next-state and next-output logic
  always_comb begin
    stateNxt   = state;
    piNxt      = pathInput;
    busyNxt    = busy;
    validNxt   = valid;
    sumNxt     = sum;
    minNxt     = minQ;
    maxNxt     = maxQ;
    runsNxt    = runsDone;
    numRunsNxt = numRunsQ;
    terrNxt    = terr;
    cntNxt     = cnt;
    streakNxt  = streak;
    sumWide    = SUM_W'(sum) + SUM_W'(cnt);

    case (state)
      IDLE: begin
        if (host.start) begin
          numRunsNxt = host.num_runs;
          sumNxt     = '0;
          minNxt     = '1;
          maxNxt     = '0;
          runsNxt    = '0;
          terrNxt    = 1'b0;
          busyNxt    = 1'b1;
          cntNxt     = '0;
          streakNxt  = '0;
          if (host.num_runs == 8'd0) begin
            validNxt = 1'b1;
            stateNxt = DONE;
          end else begin
            stateNxt = SETTLE;
          end
        end
      end
      SETTLE: begin
        if (resS == pathInput && streak == ST_W'(SETTLE_CYC - 1)) begin
          stateNxt = LAUNCH;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          terrNxt  = 1'b1;
          validNxt = 1'b1;
          stateNxt = DONE;
        end else begin
          cntNxt    = cnt + CNT_W'(1);
          streakNxt = (resS == pathInput) ? streak + ST_W'(1) : '0;
        end
      end
      LAUNCH: begin
        piNxt    = ~pathInput;
        cntNxt   = '0;
        stateNxt = WAIT;
      end
      WAIT: begin
        if (resS == pathInput) begin
          // Sum saturates rather than wrapping
          sumNxt    = sumWide[ACC_W] ? '1 : sumWide[ACC_W-1:0];
          minNxt    = (cnt < minQ) ? cnt : minQ;
          maxNxt    = (cnt > maxQ) ? cnt : maxQ;
          runsNxt   = runsDone + 8'd1;
          cntNxt    = '0;
          streakNxt = '0;
          if (runsDone + 8'd1 == numRunsQ) begin
            validNxt = 1'b1;
            stateNxt = DONE;
          end else begin
            stateNxt = SETTLE;
          end
        end else if (cnt == CNT_W'(TIMEOUT)) begin
          terrNxt  = 1'b1;
          validNxt = 1'b1;
          stateNxt = DONE;
        end else begin
          cntNxt = cnt + CNT_W'(1);
        end
      end
      DONE: begin
        if (host.result_ready) begin
          validNxt = 1'b0;
          busyNxt  = 1'b0;
          stateNxt = IDLE;
        end
      end
      default: stateNxt = IDLE;
    endcase
  end

  // State, output and synchronizer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pathInput <= 1'b0;
      busy      <= 1'b0;
      valid     <= 1'b0;
      sum       <= '0;
      minQ      <= '1;
      maxQ      <= '0;
      runsDone  <= '0;
      numRunsQ  <= '0;
      terr      <= 1'b0;
      cnt       <= '0;
      streak    <= '0;
      sync1     <= 1'b0;
      resS      <= 1'b0;
    end else begin
      state     <= stateNxt;
      pathInput <= piNxt;
      busy      <= busyNxt;
      valid     <= validNxt;
      sum       <= sumNxt;
      minQ      <= minNxt;
      maxQ      <= maxNxt;
      runsDone  <= runsNxt;
      numRunsQ  <= numRunsNxt;
      terr      <= terrNxt;
      cnt       <= cntNxt;
      streak    <= streakNxt;
      sync1     <= pathResult;
      resS      <= sync1;
    end
  end

  assign host.busy         = busy;
  assign host.result_valid = valid;
  assign host.result_sum   = sum;
  assign host.result_min   = minQ;
  assign host.result_max   = maxQ;
  assign host.runs_done    = runsDone;
  assign host.timeout_err  = terr;
endmodule

// File: tb/tb_delay_path_meas_ctrl.sv
// Directed bench for delay_path_meas_ctrl: a level-dependent registered delay chain
// model, expected results queued at start and checked at the result handshake.
module tb_delay_path_meas_ctrl;
  typedef struct {
    logic [23:0] sum;
    logic [15:0] mn;
    logic [15:0] mx;
    logic [7:0]  runs;
    logic        terr;
  } expT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pathInput;
  logic pathResult;

  delay_path_meas_ctrl_if #(.CNT_W(16), .ACC_W(24)) hostIf ();

  delay_path_meas_ctrl #(.CNT_W(16), .ACC_W(24), .TIMEOUT(1023), .SETTLE_CYC(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .host       (hostIf),
    .pathInput  (pathInput),
    .pathResult (pathResult)
  );

  always #5 clk = ~clk;

  // Chain model: registered delay chosen by the level travelling through it
  logic [15:0] sh = '0;
  int          dlyRise = 5;
  int          dlyFall = 5;
  logic        stuck = 1'b0;
  int          tapIdx;
  always @(posedge clk) sh <= {sh[14:0], pathInput};
  assign tapIdx     = (sh[0] ? dlyRise : dlyFall) - 1;
  assign pathResult = stuck ? 1'b0 : sh[tapIdx];

  int unsigned toggles = 0;
  always @(pathInput) toggles = toggles + 1;

  int  nAssert = 0;
  int  nFail   = 0;
  expT q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic expT mkExp(input int s, input int mn, input int mx, input int r, input bit t);
    expT e;
    e.sum  = 24'(s);
    e.mn   = 16'(mn);
    e.mx   = 16'(mx);
    e.runs = 8'(r);
    e.terr = t;
    return e;
  endfunction

  task automatic doStart(input logic [7:0] n, input bit push, input expT e);
    @(negedge clk);
    hostIf.start    = 1'b1;
    hostIf.num_runs = n;
    if (push) q.push_back(e);
    @(negedge clk);
    hostIf.start = 1'b0;
  endtask

  task automatic waitValid(input int budget, input string tag);
    int n = 0;
    while (hostIf.result_valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(hostIf.result_valid), 32'd1);
  endtask

  task automatic takeResult(input string tag, input bit withStart);
    expT e;
    if (q.size() == 0) begin
      nAssert++;
      nFail++;
      $error("FAIL %s observed=result expected=empty-queue", tag);
      return;
    end
    e = q.pop_front();
    check({tag, ".sum"},  32'(hostIf.result_sum),  32'(e.sum));
    check({tag, ".min"},  32'(hostIf.result_min),  32'(e.mn));
    check({tag, ".max"},  32'(hostIf.result_max),  32'(e.mx));
    check({tag, ".runs"}, 32'(hostIf.runs_done),   32'(e.runs));
    check({tag, ".terr"}, 32'(hostIf.timeout_err), 32'(e.terr));
    hostIf.result_ready = 1'b1;
    if (withStart) begin
      hostIf.start    = 1'b1;
      hostIf.num_runs = 8'd2;
    end
    @(negedge clk);
    hostIf.result_ready = 1'b0;
    hostIf.start        = 1'b0;
    check({tag, ".validDrop"}, 32'(hostIf.result_valid), 32'd0);
    check({tag, ".busyDrop"},  32'(hostIf.busy),         32'd0);
    if (withStart) begin
      @(negedge clk);
      check({tag, ".startIgnored"}, 32'(hostIf.busy), 32'd0);
    end
  endtask

  task automatic checkReset(input string tag);
    check({tag, ".pathInput"}, 32'(pathInput),           32'd0);
    check({tag, ".busy"},      32'(hostIf.busy),         32'd0);
    check({tag, ".valid"},     32'(hostIf.result_valid), 32'd0);
    check({tag, ".sum"},       32'(hostIf.result_sum),   32'd0);
    check({tag, ".min"},       32'(hostIf.result_min),   32'h0000FFFF);
    check({tag, ".max"},       32'(hostIf.result_max),   32'd0);
    check({tag, ".runs"},      32'(hostIf.runs_done),    32'd0);
    check({tag, ".terr"},      32'(hostIf.timeout_err),  32'd0);
  endtask

  task automatic waitToggles(input int unsigned base, input int unsigned want, input string tag);
    int n = 0;
    while (toggles - base < want && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(tag, toggles - base, want);
  endtask

  initial begin
    int unsigned t0;
    expT         none;
    none = mkExp(0, 0, 0, 0, 1'b0);
    hostIf.start        = 1'b0;
    hostIf.num_runs     = 8'd0;
    hostIf.result_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkReset("reset");
    rst = 1'b0;

    // Constant 5-cycle chain, four runs
    t0 = toggles;
    doStart(8'd4, 1'b1, mkExp(28, 7, 7, 4, 1'b0));
    check("t1.busy", 32'(hostIf.busy), 32'd1);
    waitValid(500, "t1.valid");
    takeResult("t1", 1'b0);
    check("t1.toggles", toggles - t0, 32'd4);
    check("t1.pathInput", 32'(pathInput), 32'd0);

    // Rising edges take 3 cycles, falling edges 9
    dlyRise = 3;
    dlyFall = 9;
    t0 = toggles;
    doStart(8'd6, 1'b1, mkExp(48, 5, 11, 6, 1'b0));
    waitValid(800, "t2.valid");
    takeResult("t2", 1'b0);
    check("t2.toggles", toggles - t0, 32'd6);

    // Single run leaves the launch level high
    dlyRise = 4;
    dlyFall = 4;
    doStart(8'd1, 1'b1, mkExp(6, 6, 6, 1, 1'b0));
    waitValid(300, "p1.valid");
    takeResult("p1", 1'b0);
    check("p1.pathInput", 32'(pathInput), 32'd1);

    // Falling run succeeds, rising run never arrives
    t0 = toggles;
    doStart(8'd3, 1'b1, mkExp(6, 6, 6, 1, 1'b1));
    waitToggles(t0, 2, "t3.secondLaunch");
    stuck = 1'b1;
    waitValid(3000, "t3.valid");
    takeResult("t3", 1'b0);
    check("t3.pathInput", 32'(pathInput), 32'd1);
    stuck = 1'b0;

    // Zero runs: immediate result, no launch
    t0 = toggles;
    doStart(8'd0, 1'b1, mkExp(0, 16'hFFFF, 0, 0, 1'b0));
    waitValid(1, "t4.valid");
    takeResult("t4", 1'b0);
    check("t4.toggles", toggles - t0, 32'd0);

    // Consumer stalls in DONE while start pulses arrive
    doStart(8'd2, 1'b1, mkExp(12, 6, 6, 2, 1'b0));
    waitValid(300, "t5.valid");
    for (int i = 0; i < 20; i++) begin
      hostIf.start    = (i % 4 == 1);
      hostIf.num_runs = 8'd7;
      @(negedge clk);
      check("t5.holdValid", 32'(hostIf.result_valid), 32'd1);
      check("t5.holdBusy",  32'(hostIf.busy),         32'd1);
      check("t5.holdSum",   32'(hostIf.result_sum),   32'(q[0].sum));
      check("t5.holdRuns",  32'(hostIf.runs_done),    32'(q[0].runs));
    end
    hostIf.start = 1'b0;
    takeResult("t5", 1'b1);

    // Reset during the second run's wait, then a clean measurement
    t0 = toggles;
    doStart(8'd3, 1'b0, none);
    waitToggles(t0, 2, "t6.secondLaunch");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkReset("t6.rst");
    rst = 1'b0;
    t0 = toggles;
    doStart(8'd3, 1'b1, mkExp(18, 6, 6, 3, 1'b0));
    waitValid(400, "t6.valid");
    takeResult("t6", 1'b0);
    check("t6.toggles", toggles - t0, 32'd3);
    check("queueEmpty", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end
endmodule
